// File: rtl/axi_pkg.sv
// AXI4 channel bundles shared by masters, arbiter and slave model.
package axi_pkg;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Master-driven side of all five channels.
  typedef struct packed {
    logic [ID_W-1:0]     aw_id;
    logic [ADDR_W-1:0]   aw_addr;
    logic [7:0]          aw_len;
    logic [2:0]          aw_size;
    logic [1:0]          aw_burst;
    logic                aw_valid;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_last;
    logic                w_valid;
    logic                b_ready;
    logic [ID_W-1:0]     ar_id;
    logic [ADDR_W-1:0]   ar_addr;
    logic [7:0]          ar_len;
    logic [2:0]          ar_size;
    logic [1:0]          ar_burst;
    logic                ar_valid;
    logic                r_ready;
  } axi_req_t;

  // Slave-driven side of all five channels.
  typedef struct packed {
    logic                aw_ready;
    logic                w_ready;
    logic [ID_W-1:0]     b_id;
    logic [1:0]          b_resp;
    logic                b_valid;
    logic                ar_ready;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_resp;
    logic                r_last;
    logic                r_valid;
  } axi_resp_t;

endpackage

// File: rtl/dma_pkg.sv
// Arbitration mode and per-path FSM state encodings for the DMA front end.
package dma_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating picker: first requester at or after ptr, wrapping.
// With ptr tied to zero it degenerates to lowest-index-wins priority.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk the N positions starting at ptr and keep the first active request.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/axi_master_arbiter.sv
// N-master to 1-slave AXI4 arbiter with independent write and read paths.
// Each grant is held for a whole transaction (address, data, response).
module axi_master_arbiter
  import axi_pkg::*;
  import dma_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ARB_MODE    = 1,
  parameter int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  axi_req_t         axi_req_i [NUM_MASTERS],
  output axi_resp_t        axi_resp_o [NUM_MASTERS],
  output axi_req_t         axi_req_o,
  input  axi_resp_t        axi_resp_i,
  input  logic             force_en_i,
  input  logic [IDX_W-1:0] force_sel_i,
  output logic             wr_busy_o,
  output logic             rd_busy_o,
  output logic [IDX_W-1:0] wr_owner_o,
  output logic [IDX_W-1:0] rd_owner_o
);

  localparam arb_mode_e MODE = (ARB_MODE == 0) ? ARB_FIXED : ARB_RR;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

  wr_state_e        wr_state_reg, wr_state_next;
  rd_state_e        rd_state_reg, rd_state_next;
  logic [IDX_W-1:0] wr_owner_reg, rd_owner_reg;
  logic [IDX_W-1:0] wr_rr_ptr_reg, rd_rr_ptr_reg;
  logic [IDX_W-1:0] wr_rr_ptr_next, rd_rr_ptr_next;

  logic [NUM_MASTERS-1:0] wr_req, rd_req;
  logic [NUM_MASTERS-1:0] wr_gnt, rd_gnt;
  logic [IDX_W-1:0]       wr_pick_idx, rd_pick_idx;
  logic [IDX_W-1:0]       wr_ptr_eff, rd_ptr_eff;
  logic                   wr_grant, rd_grant;

  axi_req_t wr_sel, rd_sel;
  logic     aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;

  // Candidate sets: address valids, restricted to the forced master when forcing.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
    assign wr_req[gi] = axi_req_i[gi].aw_valid &&
                        (!force_en_i || (force_sel_i == IDX_W'(gi)));
    assign rd_req[gi] = axi_req_i[gi].ar_valid &&
                        (!force_en_i || (force_sel_i == IDX_W'(gi)));
  end

  // Fixed priority is the rotating picker with its pointer pinned to zero.
  assign wr_ptr_eff = (MODE == ARB_RR) ? wr_rr_ptr_reg : '0;
  assign rd_ptr_eff = (MODE == ARB_RR) ? rd_rr_ptr_reg : '0;

  rr_pick #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_wr_pick (
    .req (wr_req),
    .ptr (wr_ptr_eff),
    .gnt (wr_gnt),
    .idx (wr_pick_idx)
  );

  rr_pick #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_rd_pick (
    .req (rd_req),
    .ptr (rd_ptr_eff),
    .gnt (rd_gnt),
    .idx (rd_pick_idx)
  );

  assign wr_grant = (wr_state_reg == W_IDLE) && (|wr_gnt);
  assign rd_grant = (rd_state_reg == R_IDLE) && (|rd_gnt);

  assign wr_rr_ptr_next = (wr_pick_idx == LAST_IDX) ? '0 : wr_pick_idx + IDX_W'(1);
  assign rd_rr_ptr_next = (rd_pick_idx == LAST_IDX) ? '0 : rd_pick_idx + IDX_W'(1);

  // The owner's request bundle steers everything on each path.
  assign wr_sel = axi_req_i[wr_owner_reg];
  assign rd_sel = axi_req_i[rd_owner_reg];

  assign aw_hs     = (wr_state_reg == W_ADDR) && wr_sel.aw_valid && axi_resp_i.aw_ready;
  assign w_last_hs = (wr_state_reg == W_DATA) && wr_sel.w_valid && axi_resp_i.w_ready &&
                     wr_sel.w_last;
  assign b_hs      = (wr_state_reg == W_RESP) && axi_resp_i.b_valid && wr_sel.b_ready;
  assign ar_hs     = (rd_state_reg == R_ADDR) && rd_sel.ar_valid && axi_resp_i.ar_ready;
  assign r_last_hs = (rd_state_reg == R_DATA) && axi_resp_i.r_valid && rd_sel.r_ready &&
                     axi_resp_i.r_last;

  // Write path sequencing: arbitrate, AW, W burst until wlast, B.
  always_comb begin
    wr_state_next = wr_state_reg;
    case (wr_state_reg)
      W_IDLE:  if (wr_grant)  wr_state_next = W_ADDR;
      W_ADDR:  if (aw_hs)     wr_state_next = W_DATA;
      W_DATA:  if (w_last_hs) wr_state_next = W_RESP;
      W_RESP:  if (b_hs)      wr_state_next = W_IDLE;
      default:                wr_state_next = W_IDLE;
    endcase
  end

  // Read path sequencing: arbitrate, AR, R burst until rlast.
  always_comb begin
    rd_state_next = rd_state_reg;
    case (rd_state_reg)
      R_IDLE:  if (rd_grant)  rd_state_next = R_ADDR;
      R_ADDR:  if (ar_hs)     rd_state_next = R_DATA;
      R_DATA:  if (r_last_hs) rd_state_next = R_IDLE;
      default:                rd_state_next = R_IDLE;
    endcase
  end

  // Write state, owner and pointer; owner and pointer move only on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_reg  <= W_IDLE;
      wr_owner_reg  <= '0;
      wr_rr_ptr_reg <= '0;
    end else begin
      wr_state_reg <= wr_state_next;
      if (wr_grant) begin
        wr_owner_reg <= wr_pick_idx;
        if (MODE == ARB_RR) begin
          wr_rr_ptr_reg <= wr_rr_ptr_next;
        end
      end
    end
  end

  // Read state, owner and pointer; owner and pointer move only on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_reg  <= R_IDLE;
      rd_owner_reg  <= '0;
      rd_rr_ptr_reg <= '0;
    end else begin
      rd_state_reg <= rd_state_next;
      if (rd_grant) begin
        rd_owner_reg <= rd_pick_idx;
        if (MODE == ARB_RR) begin
          rd_rr_ptr_reg <= rd_rr_ptr_next;
        end
      end
    end
  end

  // Slave side: owner payloads pass through, valids/readies only in their state.
  always_comb begin
    axi_req_o          = wr_sel;
    axi_req_o.ar_id    = rd_sel.ar_id;
    axi_req_o.ar_addr  = rd_sel.ar_addr;
    axi_req_o.ar_len   = rd_sel.ar_len;
    axi_req_o.ar_size  = rd_sel.ar_size;
    axi_req_o.ar_burst = rd_sel.ar_burst;
    axi_req_o.aw_valid = (wr_state_reg == W_ADDR) && wr_sel.aw_valid;
    axi_req_o.w_valid  = (wr_state_reg == W_DATA) && wr_sel.w_valid;
    axi_req_o.b_ready  = (wr_state_reg == W_RESP) && wr_sel.b_ready;
    axi_req_o.ar_valid = (rd_state_reg == R_ADDR) && rd_sel.ar_valid;
    axi_req_o.r_ready  = (rd_state_reg == R_DATA) && rd_sel.r_ready;
  end

  // Master side: response payload is broadcast, handshakes reach only the owner.
  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      axi_resp_o[m]          = axi_resp_i;
      axi_resp_o[m].aw_ready = (wr_owner_reg == IDX_W'(m)) && (wr_state_reg == W_ADDR) &&
                               axi_resp_i.aw_ready;
      axi_resp_o[m].w_ready  = (wr_owner_reg == IDX_W'(m)) && (wr_state_reg == W_DATA) &&
                               axi_resp_i.w_ready;
      axi_resp_o[m].b_valid  = (wr_owner_reg == IDX_W'(m)) && (wr_state_reg == W_RESP) &&
                               axi_resp_i.b_valid;
      axi_resp_o[m].ar_ready = (rd_owner_reg == IDX_W'(m)) && (rd_state_reg == R_ADDR) &&
                               axi_resp_i.ar_ready;
      axi_resp_o[m].r_valid  = (rd_owner_reg == IDX_W'(m)) && (rd_state_reg == R_DATA) &&
                               axi_resp_i.r_valid;
    end
  end

  assign wr_busy_o  = (wr_state_reg != W_IDLE);
  assign rd_busy_o  = (rd_state_reg != R_IDLE);
  assign wr_owner_o = wr_owner_reg;
  assign rd_owner_o = rd_owner_reg;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter: a round-robin and a fixed-priority
// instance with four masters share the same stimulus and slave responses.
module tb_axi_master_arbiter;
  import axi_pkg::*;

  localparam int NM = 4;

  logic      clk = 1'b0;
  logic      rst;
  axi_req_t  m_req [NM];
  axi_resp_t rr_resp [NM];
  axi_resp_t fx_resp [NM];
  axi_req_t  rr_sreq, fx_sreq;
  axi_resp_t s_resp;
  logic       force_en;
  logic [1:0] force_sel;
  logic       rr_wr_busy, rr_rd_busy, fx_wr_busy, fx_rd_busy;
  logic [1:0] rr_wr_owner, rr_rd_owner, fx_wr_owner, fx_rd_owner;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_master_arbiter #(.NUM_MASTERS(NM), .ARB_MODE(1)) dut_rr (
    .clk         (clk),
    .rst         (rst),
    .axi_req_i   (m_req),
    .axi_resp_o  (rr_resp),
    .axi_req_o   (rr_sreq),
    .axi_resp_i  (s_resp),
    .force_en_i  (force_en),
    .force_sel_i (force_sel),
    .wr_busy_o   (rr_wr_busy),
    .rd_busy_o   (rr_rd_busy),
    .wr_owner_o  (rr_wr_owner),
    .rd_owner_o  (rr_rd_owner)
  );

  axi_master_arbiter #(.NUM_MASTERS(NM), .ARB_MODE(0)) dut_fx (
    .clk         (clk),
    .rst         (rst),
    .axi_req_i   (m_req),
    .axi_resp_o  (fx_resp),
    .axi_req_o   (fx_sreq),
    .axi_resp_i  (s_resp),
    .force_en_i  (force_en),
    .force_sel_i (force_sel),
    .wr_busy_o   (fx_wr_busy),
    .rd_busy_o   (fx_rd_busy),
    .wr_owner_o  (fx_wr_owner),
    .rd_owner_o  (fx_rd_owner)
  );

  typedef struct {
    logic [3:0] aw_req;
    logic       f_en;
    logic [1:0] f_sel;
    logic       exp_busy;
    logic [1:0] exp_rr;
    logic [1:0] exp_fx;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic logic [31:0] maddr(input int m);
    return 32'h1100_0000 + 32'(m) * 32'h0100_0000;
  endfunction

  function automatic logic [31:0] mdata(input int m);
    return 32'hD00D_0000 + 32'(m);
  endfunction

  function automatic logic [4:0] s_valids(input axi_req_t r);
    return {r.aw_valid, r.w_valid, r.b_ready, r.ar_valid, r.r_ready};
  endfunction

  function automatic logic [4:0] m_hands(input axi_resp_t r);
    return {r.aw_ready, r.w_ready, r.b_valid, r.ar_ready, r.r_valid};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // arbitration table: hand-computed owners, rr pointer starts at 0
    vecs[0]  = '{4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0};
    vecs[1]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0};
    vecs[2]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 2'd1, 2'd0};
    vecs[3]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 2'd2, 2'd0};
    vecs[4]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 2'd3, 2'd0};
    vecs[5]  = '{4'b1010, 1'b0, 2'd0, 1'b1, 2'd1, 2'd1};
    vecs[6]  = '{4'b1010, 1'b0, 2'd0, 1'b1, 2'd3, 2'd1};
    vecs[7]  = '{4'b1010, 1'b0, 2'd0, 1'b1, 2'd1, 2'd1};
    vecs[8]  = '{4'b0001, 1'b1, 2'd2, 1'b0, 2'd1, 2'd1};
    vecs[9]  = '{4'b0101, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2};
    vecs[10] = '{4'b0001, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0};
    vecs[11] = '{4'b1000, 1'b0, 2'd0, 1'b1, 2'd3, 2'd3};
    vecs[12] = '{4'b0110, 1'b0, 2'd0, 1'b1, 2'd1, 2'd1};
    vecs[13] = '{4'b0110, 1'b1, 2'd3, 1'b0, 2'd1, 2'd1};
    vecs[14] = '{4'b1001, 1'b0, 2'd0, 1'b1, 2'd3, 2'd0};

    for (int m = 0; m < NM; m++) begin
      m_req[m]         = '0;
      m_req[m].aw_id   = 4'(m);
      m_req[m].aw_addr = maddr(m);
      m_req[m].w_data  = mdata(m);
      m_req[m].w_strb  = '1;
      m_req[m].w_valid = 1'b1;
      m_req[m].w_last  = 1'b1;
      m_req[m].b_ready = 1'b1;
      m_req[m].ar_id   = 4'(m);
      m_req[m].ar_addr = maddr(m) + 32'h100;
      m_req[m].ar_len  = 8'd15;
      m_req[m].r_ready = 1'b1;
    end
    force_en  = 1'b0;
    force_sel = 2'd0;

    // reset: slave offers every handshake, nothing may reach any master
    rst = 1'b1;
    s_resp = '0;
    s_resp.aw_ready = 1'b1;
    s_resp.w_ready  = 1'b1;
    s_resp.b_valid  = 1'b1;
    s_resp.ar_ready = 1'b1;
    s_resp.r_valid  = 1'b1;
    tick();
    tick();
    chk("reset_wr_busy", 32'({rr_wr_busy, fx_wr_busy}), 32'd0);
    chk("reset_rd_busy", 32'({rr_rd_busy, fx_rd_busy}), 32'd0);
    chk("reset_owners", 32'({rr_wr_owner, rr_rd_owner, fx_wr_owner, fx_rd_owner}), 32'd0);
    chk("reset_slave_valids", 32'({s_valids(rr_sreq), s_valids(fx_sreq)}), 32'd0);
    for (int m = 0; m < NM; m++) begin
      chk($sformatf("reset_m%0d_hands", m), 32'({m_hands(rr_resp[m]), m_hands(fx_resp[m])}), 32'd0);
    end
    $display("[TB] reset done");
    rst = 1'b0;
    s_resp = '0;

    // table-driven write arbitration, one single-beat transaction per vector
    for (int v = 0; v < NV; v++) begin
      for (int m = 0; m < NM; m++) m_req[m].aw_valid = vecs[v].aw_req[m];
      force_en  = vecs[v].f_en;
      force_sel = vecs[v].f_sel;
      tick();
      chk($sformatf("v%0d_rr_busy", v), 32'(rr_wr_busy), 32'(vecs[v].exp_busy));
      chk($sformatf("v%0d_fx_busy", v), 32'(fx_wr_busy), 32'(vecs[v].exp_busy));
      chk($sformatf("v%0d_rr_owner", v), 32'(rr_wr_owner), 32'(vecs[v].exp_rr));
      chk($sformatf("v%0d_fx_owner", v), 32'(fx_wr_owner), 32'(vecs[v].exp_fx));
      chk($sformatf("v%0d_rr_awvalid", v), 32'(rr_sreq.aw_valid), 32'(vecs[v].exp_busy));
      if (vecs[v].exp_busy) begin
        chk($sformatf("v%0d_rr_awaddr", v), rr_sreq.aw_addr, maddr(int'(vecs[v].exp_rr)));
        chk($sformatf("v%0d_fx_awaddr", v), fx_sreq.aw_addr, maddr(int'(vecs[v].exp_fx)));
        s_resp.aw_ready = 1'b1;
        #1;
        for (int m = 0; m < NM; m++) begin
          chk($sformatf("v%0d_rr_m%0d_awready", v, m), 32'(rr_resp[m].aw_ready),
              32'(m == int'(vecs[v].exp_rr)));
          chk($sformatf("v%0d_fx_m%0d_awready", v, m), 32'(fx_resp[m].aw_ready),
              32'(m == int'(vecs[v].exp_fx)));
        end
        tick();
        for (int m = 0; m < NM; m++) m_req[m].aw_valid = 1'b0;
        s_resp.aw_ready = 1'b0;
        s_resp.w_ready  = 1'b1;
        #1;
        chk($sformatf("v%0d_rr_wdata", v), rr_sreq.w_data, mdata(int'(vecs[v].exp_rr)));
        chk($sformatf("v%0d_fx_wdata", v), fx_sreq.w_data, mdata(int'(vecs[v].exp_fx)));
        tick();
        s_resp.w_ready = 1'b0;
        s_resp.b_valid = 1'b1;
        #1;
        for (int m = 0; m < NM; m++) begin
          chk($sformatf("v%0d_rr_m%0d_bvalid", v, m), 32'(rr_resp[m].b_valid),
              32'(m == int'(vecs[v].exp_rr)));
        end
        tick();
        s_resp.b_valid = 1'b0;
      end
      chk($sformatf("v%0d_rr_idle_after", v), 32'(rr_wr_busy), 32'd0);
      $display("[TB] vec %0d req=%b rr_owner=%0d fx_owner=%0d busy=%0b",
               v, vecs[v].aw_req, rr_wr_owner, fx_wr_owner, vecs[v].exp_busy);
    end
    for (int m = 0; m < NM; m++) m_req[m].aw_valid = 1'b0;
    force_en = 1'b0;

    // 16-beat read by master 0, force to master 1 raised mid-burst
    m_req[0].ar_valid = 1'b1;
    tick();
    chk("rd_grant_m0_busy", 32'({rr_rd_busy, fx_rd_busy}), 32'b11);
    chk("rd_grant_m0_owner", 32'({rr_rd_owner, fx_rd_owner}), 32'd0);
    chk("rd_grant_m0_araddr", rr_sreq.ar_addr, maddr(0) + 32'h100);
    s_resp.ar_ready = 1'b1;
    #1;
    chk("rd_m0_arready", 32'({rr_resp[0].ar_ready, rr_resp[1].ar_ready}), 32'b10);
    tick();
    s_resp.ar_ready = 1'b0;
    force_en  = 1'b1;
    force_sel = 2'd1;
    m_req[1].ar_valid = 1'b1;
    for (int b = 0; b < 16; b++) begin
      s_resp.r_valid = 1'b1;
      s_resp.r_last  = (b == 15);
      s_resp.r_data  = 32'(b);
      #1;
      chk($sformatf("rd_beat%0d_rvalid", b),
          32'({rr_resp[0].r_valid, rr_resp[1].r_valid, fx_resp[0].r_valid, fx_resp[1].r_valid}),
          32'b1010);
      chk($sformatf("rd_beat%0d_owner_busy", b), 32'({rr_rd_owner, rr_rd_busy}), 32'b001);
      tick();
    end
    $display("[TB] read burst m0 done, 16 beats");
    s_resp.r_valid = 1'b0;
    s_resp.r_last  = 1'b0;
    chk("rd_idle_after_rlast", 32'({rr_rd_busy, fx_rd_busy}), 32'd0);
    tick();
    chk("rd_force_grant_owner", 32'({rr_rd_owner, fx_rd_owner}), 32'b0101);
    s_resp.ar_ready = 1'b1;
    #1;
    chk("rd_force_arready", 32'({rr_resp[0].ar_ready, rr_resp[1].ar_ready,
                                 fx_resp[0].ar_ready, fx_resp[1].ar_ready}), 32'b0101);
    tick();
    s_resp.ar_ready = 1'b0;
    m_req[0].ar_valid = 1'b0;
    m_req[1].ar_valid = 1'b0;
    s_resp.r_valid = 1'b1;
    s_resp.r_last  = 1'b1;
    #1;
    chk("rd_m1_rvalid", 32'({rr_resp[0].r_valid, rr_resp[1].r_valid}), 32'b01);
    tick();
    s_resp.r_valid = 1'b0;
    s_resp.r_last  = 1'b0;
    force_en = 1'b0;
    $display("[TB] forced read m1 done");

    // concurrent write by master 0 and read by master 1
    m_req[0].aw_valid = 1'b1;
    m_req[1].ar_valid = 1'b1;
    tick();
    chk("dual_busy", 32'({rr_wr_busy, rr_rd_busy}), 32'b11);
    chk("dual_owners", 32'({rr_wr_owner, rr_rd_owner}), 32'b0001);
    chk("dual_awaddr", rr_sreq.aw_addr, maddr(0));
    chk("dual_araddr", rr_sreq.ar_addr, maddr(1) + 32'h100);
    s_resp.aw_ready = 1'b1;
    s_resp.ar_ready = 1'b1;
    tick();
    m_req[0].aw_valid = 1'b0;
    m_req[1].ar_valid = 1'b0;
    s_resp.aw_ready = 1'b0;
    s_resp.ar_ready = 1'b0;
    s_resp.w_ready  = 1'b1;
    s_resp.r_valid  = 1'b1;
    s_resp.r_last   = 1'b1;
    #1;
    chk("dual_routing", 32'({rr_resp[0].w_ready, rr_resp[1].w_ready,
                             rr_resp[0].r_valid, rr_resp[1].r_valid}), 32'b1001);
    tick();
    s_resp.w_ready = 1'b0;
    s_resp.r_valid = 1'b0;
    s_resp.r_last  = 1'b0;
    s_resp.b_valid = 1'b1;
    #1;
    chk("dual_bvalid_rd_idle", 32'({rr_resp[0].b_valid, rr_resp[1].b_valid, rr_rd_busy}), 32'b100);
    tick();
    s_resp.b_valid = 1'b0;
    chk("dual_wr_idle", 32'(rr_wr_busy), 32'd0);
    $display("[TB] concurrent write m0 / read m1 done");

    // reset during the fifth W beat of master 2's burst
    for (int m = 0; m < NM; m++) m_req[m].w_last = 1'b0;
    m_req[2].aw_valid = 1'b1;
    tick();
    chk("rst_seq_owner", 32'({rr_wr_owner, fx_wr_owner}), 32'b1010);
    s_resp.aw_ready = 1'b1;
    tick();
    m_req[2].aw_valid = 1'b0;
    s_resp.aw_ready = 1'b0;
    s_resp.w_ready  = 1'b1;
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("rst_seq_beat%0d_wdata", b), rr_sreq.w_data, mdata(2));
      chk($sformatf("rst_seq_beat%0d_wvalid", b), 32'({rr_sreq.w_valid, rr_wr_busy}), 32'b11);
      tick();
    end
    rst = 1'b1;
    tick();
    chk("rst_mid_slave_valids", 32'({s_valids(rr_sreq), s_valids(fx_sreq)}), 32'd0);
    chk("rst_mid_busy_owner", 32'({rr_wr_busy, fx_wr_busy, rr_wr_owner}), 32'd0);
    rst = 1'b0;
    s_resp.w_ready = 1'b0;
    m_req[2].aw_valid = 1'b1;
    tick();
    chk("rst_regrant_busy_owner", 32'({rr_wr_busy, rr_wr_owner}), 32'b110);
    chk("rst_regrant_awaddr", rr_sreq.aw_addr, maddr(2));
    chk("rst_regrant_awvalid", 32'(rr_sreq.aw_valid), 32'd1);
    $display("[TB] reset mid-burst and regrant done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
